// File: rtl/lcd_frame_writer_if.sv
// Signal bundle between the screen selector, the LCD frame writer and the LCD pins.
// master is the frame writer side; slave is the side that supplies text and watches the pins.
interface lcd_frame_writer_if;
    logic [127:0] line1;
    logic [127:0] line2;
    logic [7:0]   LCD_DATA;
    logic         LCD_RW;
    logic         LCD_EN;
    logic         LCD_RS;
    logic         frame_done;

    modport master (
        input  line1, line2,
        output LCD_DATA, LCD_RW, LCD_EN, LCD_RS, frame_done
    );

    modport slave (
        output line1, line2,
        input  LCD_DATA, LCD_RW, LCD_EN, LCD_RS, frame_done
    );
endinterface

// File: rtl/lcd_frame_writer.sv
// HD44780 8-bit write-only driver: power-up wait, one-shot init, then endless refresh of
// two 16-character lines taken from a per-frame snapshot.
module lcd_frame_writer #(
    parameter int EN_HIGH     = 12,
    parameter int CMD_WAIT    = 2000,
    parameter int CLR_WAIT    = 82000,
    parameter int PWRUP_WAIT  = 1000000,
    parameter int REFRESH_GAP = 50000
) (
    input  logic                iCLK,
    input  logic                reset,
    lcd_frame_writer_if.master  bus
);
    localparam int MAX_A = (EN_HIGH > CMD_WAIT) ? EN_HIGH : CMD_WAIT;
    localparam int MAX_B = (CLR_WAIT > REFRESH_GAP) ? CLR_WAIT : REFRESH_GAP;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_C > PWRUP_WAIT) ? MAX_C : PWRUP_WAIT;
    localparam int CNT_W = $clog2(MAX_P + 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_SNAP, S_L1ADDR, S_L1CHAR, S_L2ADDR, S_L2CHAR, S_GAP
    } top_t;

    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD, P_WAIT} phase_t;

    top_t               r_top, w_top_nxt;
    phase_t             r_phase, w_phase_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_wait_len;
    logic [3:0]         r_idx, w_idx_nxt;
    logic [127:0]       r_snap1, r_snap2;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_rs, w_rs_nxt;
    logic               r_en, r_done;
    logic               w_snap_en, w_load;

    function automatic logic is_byte(input top_t t);
        return (t != S_PWRUP) && (t != S_SNAP) && (t != S_GAP);
    endfunction

    // Index 0 is the leftmost character, held in the top byte of the line.
    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] idx);
        return line[{~idx, 3'b000} +: 8];
    endfunction

    always_ff @(posedge iCLK) begin
        if (reset) begin
            r_top   <= S_PWRUP;
            r_phase <= P_SETUP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_top   <= w_top_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_en    <= is_byte(w_top_nxt) && (w_phase_nxt == P_PULSE);
            r_done  <= (w_top_nxt == S_GAP) && (r_top != S_GAP);
            if (w_load) begin
                r_data <= w_data_nxt;
                r_rs   <= w_rs_nxt;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_snap_en) begin
            r_snap1 <= bus.line1;
            r_snap2 <= bus.line2;
        end
    end

    always_comb begin
        w_top_nxt   = r_top;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_snap_en   = 1'b0;
        w_wait_len  = (r_top == S_INIT && r_idx == 4'd2) ? CNT_W'(CLR_WAIT) : CNT_W'(CMD_WAIT);
        case (r_top)
            S_PWRUP: begin
                if (r_cnt == CNT_W'(PWRUP_WAIT)) begin
                    w_top_nxt   = S_INIT;
                    w_phase_nxt = P_SETUP;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_SNAP: begin
                w_snap_en   = 1'b1;
                w_top_nxt   = S_L1ADDR;
                w_phase_nxt = P_SETUP;
                w_cnt_nxt   = '0;
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(REFRESH_GAP - 1)) begin
                    w_top_nxt = S_SNAP;
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                case (r_phase)
                    P_SETUP: begin
                        w_phase_nxt = P_PULSE;
                        w_cnt_nxt   = '0;
                    end
                    P_PULSE: begin
                        if (r_cnt == CNT_W'(EN_HIGH - 1)) begin
                            w_phase_nxt = P_HOLD;
                            w_cnt_nxt   = '0;
                        end
                    end
                    P_HOLD: begin
                        w_phase_nxt = P_WAIT;
                        w_cnt_nxt   = '0;
                    end
                    default: begin
                        if (r_cnt == w_wait_len - 1'b1) begin
                            // Byte finished: pick the next byte or the next top state.
                            w_phase_nxt = P_SETUP;
                            w_cnt_nxt   = '0;
                            case (r_top)
                                S_INIT: begin
                                    if (r_idx == 4'd3) w_top_nxt = S_SNAP;
                                    else               w_idx_nxt = r_idx + 4'd1;
                                end
                                S_L1ADDR: begin
                                    w_top_nxt = S_L1CHAR;
                                    w_idx_nxt = '0;
                                end
                                S_L1CHAR: begin
                                    if (r_idx == 4'd15) w_top_nxt = S_L2ADDR;
                                    else                w_idx_nxt = r_idx + 4'd1;
                                end
                                S_L2ADDR: begin
                                    w_top_nxt = S_L2CHAR;
                                    w_idx_nxt = '0;
                                end
                                default: begin
                                    if (r_idx == 4'd15) w_top_nxt = S_GAP;
                                    else                w_idx_nxt = r_idx + 4'd1;
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    // Data and RS only move on entry to SETUP, so they are frozen through PULSE, HOLD and WAIT.
    always_comb begin
        w_load     = is_byte(w_top_nxt) && (w_phase_nxt == P_SETUP);
        w_data_nxt = 8'h00;
        w_rs_nxt   = 1'b0;
        case (w_top_nxt)
            S_INIT: begin
                case (w_idx_nxt[1:0])
                    2'd0:    w_data_nxt = 8'h38;
                    2'd1:    w_data_nxt = 8'h0C;
                    2'd2:    w_data_nxt = 8'h01;
                    default: w_data_nxt = 8'h06;
                endcase
            end
            S_L1ADDR: w_data_nxt = 8'h80;
            S_L2ADDR: w_data_nxt = 8'hC0;
            S_L1CHAR: begin
                w_data_nxt = char_at(r_snap1, w_idx_nxt);
                w_rs_nxt   = 1'b1;
            end
            S_L2CHAR: begin
                w_data_nxt = char_at(r_snap2, w_idx_nxt);
                w_rs_nxt   = 1'b1;
            end
            default: begin
                w_data_nxt = 8'h00;
                w_rs_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.LCD_DATA   = r_data;
    assign bus.LCD_RS     = r_rs;
    assign bus.LCD_EN     = r_en;
    assign bus.LCD_RW     = 1'b0;
    assign bus.frame_done = r_done;
endmodule
